if_fetch_unit: RTL and testbench

- IF stage of the pipelined DLX; sits directly upstream of the IF/ID pipeline register and produces its 64-bit input packet {PC+4, instruction}.
- Owns the PC. Runs a req/ack handshake to instruction memory, which may have variable latency.
- Holds a fetched instruction while the hazard unit stalls. Applies branch/jump redirects, including redirects that arrive while a memory access is in flight.

---
 rtl/if_fetch_unit.sv | 143 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// DLX instruction-fetch stage: owns the PC, runs the imem req/ack handshake, holds on stall, applies redirects.
// Optional performance counters are enabled with the IF_FETCH_PERF_CNT_EN macro.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          WIDTH    = 64
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    input  logic             stall,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic [WIDTH-1:0] if_pkt,
    output logic             if_valid,
    output logic             fetch_busy
`ifdef IF_FETCH_PERF_CNT_EN
    ,
    output logic [31:0]      perf_fetched,
    output logic [31:0]      perf_stall_cycles
`endif
);

    // state | meaning
    // FETCH | request outstanding at pc; delivers the word on ack
    // HOLD  | fetched word parked in hold_instr while IF/ID is stalled
    // DRAIN | redirect arrived mid-access; finish it, then jump to pend_pc
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] hold_instr, hold_nxt;
    logic [31:0] pend_pc, pend_nxt;
    logic [31:0] pc_plus4;
    logic [31:0] redir_target;
    logic [31:0] instr_out;
    logic        req_int;
    logic        valid_int;
    logic        busy_int;

    assign pc_plus4     = pc + 32'd4;
    assign redir_target = redirect_pc & 32'hFFFF_FFFC;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= FETCH;
            pc         <= RESET_PC & 32'hFFFF_FFFC;
            hold_instr <= 32'h0;
            pend_pc    <= 32'h0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            hold_instr <= hold_nxt;
            pend_pc    <= pend_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        hold_nxt  = hold_instr;
        pend_nxt  = pend_pc;
        req_int   = 1'b0;
        valid_int = 1'b0;
        busy_int  = 1'b0;
        instr_out = 32'h0;
        case (state)
            FETCH: begin
                req_int = 1'b1;
                if (!imem_ack) begin
                    busy_int = 1'b1;
                    if (redirect) begin
                        pend_nxt  = redir_target;
                        state_nxt = DRAIN;
                    end
                end else if (redirect) begin
                    pc_nxt = redir_target;
                end else begin
                    valid_int = 1'b1;
                    instr_out = imem_rdata;
                    if (!stall) begin
                        pc_nxt = pc_plus4;
                    end else begin
                        hold_nxt  = imem_rdata;
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                valid_int = 1'b1;
                instr_out = hold_instr;
                if (redirect) begin
                    pc_nxt    = redir_target;
                    state_nxt = FETCH;
                end else if (!stall) begin
                    pc_nxt    = pc_plus4;
                    state_nxt = FETCH;
                end
            end
            DRAIN: begin
                req_int  = 1'b1;
                busy_int = 1'b1;
                // Address stays on the abandoned access until memory acks it
                if (imem_ack) begin
                    pc_nxt    = redirect ? redir_target : pend_pc;
                    state_nxt = FETCH;
                end else if (redirect) begin
                    pend_nxt = redir_target;
                end
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    assign imem_req   = rst & req_int;
    assign if_valid   = rst & valid_int;
    assign fetch_busy = rst & busy_int;
    assign imem_addr  = pc;
    assign if_pkt     = rst ? {pc_plus4, instr_out} : {WIDTH{1'b0}};

`ifdef IF_FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_fetched      <= 32'h0;
            perf_stall_cycles <= 32'h0;
        end else begin
            if (if_valid && !stall && !redirect)
                perf_fetched <= perf_fetched + 32'd1;
            if (if_valid && stall)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: sequential fetch, stall/hold, drain redirects, reset, PC wrap.
// Memory returns addr ^ 32'hA500_0000 so expected instruction words are easy to hand-compute.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ack_auto;
    logic        ack_man;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [63:0] if_pkt;
    logic        if_valid;
    logic        fetch_busy;

    logic        imem_req_w;
    logic [31:0] imem_addr_w;
    logic        imem_ack_w;
    logic [63:0] if_pkt_w;
    logic        if_valid_w;
    logic        fetch_busy_w;

`ifdef IF_FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stall_cycles;
    logic [31:0] perf_fetched_w, perf_stall_cycles_w;
`endif

    int n_cmp = 0;
    int n_err = 0;

    assign imem_ack   = ack_auto ? imem_req : ack_man;
    assign imem_rdata = imem_addr ^ 32'hA500_0000;
    assign imem_ack_w = imem_req_w;

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_pkt      (if_pkt),
        .if_valid    (if_valid),
        .fetch_busy  (fetch_busy)
`ifdef IF_FETCH_PERF_CNT_EN
        ,
        .perf_fetched      (perf_fetched),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    // Second instance checks PC+4 wrap from the top of the address space
    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req_w),
        .imem_addr   (imem_addr_w),
        .imem_ack    (imem_ack_w),
        .imem_rdata  (32'h1234_5678),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_pkt      (if_pkt_w),
        .if_valid    (if_valid_w),
        .fetch_busy  (fetch_busy_w)
`ifdef IF_FETCH_PERF_CNT_EN
        ,
        .perf_fetched      (perf_fetched_w),
        .perf_stall_cycles (perf_stall_cycles_w)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ins(input logic [31:0] a);
        return a ^ 32'hA500_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        ack_auto = 1'b0; ack_man = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        smp();
        check("rst_req",   64'(imem_req),   64'h0);
        check("rst_valid", 64'(if_valid),   64'h0);
        check("rst_pkt",   if_pkt,          64'h0);
        check("rst_busy",  64'(fetch_busy), 64'h0);

        // Single-cycle memory, no stall: zero-bubble stream
        tick(); rst = 1'b1; ack_auto = 1'b1;
        smp();
        check("seq0_addr",  64'(imem_addr), 64'h0);
        check("seq0_valid", 64'(if_valid),  64'h1);
        check("seq0_pkt",   if_pkt, {32'h4, ins(32'h0)});
        check("seq0_busy",  64'(fetch_busy), 64'h0);
        check("wrap_pkt",   if_pkt_w, {32'h0, 32'h1234_5678});
        check("wrap_addr",  64'(imem_addr_w), 64'hFFFF_FFFC);
        tick();
        smp();
        check("seq1_addr", 64'(imem_addr), 64'h4);
        check("seq1_pkt",  if_pkt, {32'h8, ins(32'h4)});

        // Stall on the ack at 8 -> HOLD
        tick(); stall = 1'b1;
        smp();
        check("stl_addr",  64'(imem_addr), 64'h8);
        check("stl_valid", 64'(if_valid),  64'h1);
        check("stl_pkt",   if_pkt, {32'hC, ins(32'h8)});
        for (int k = 0; k < 3; k++) begin
            tick();
            smp();
            check("hold_req",   64'(imem_req), 64'h0);
            check("hold_valid", 64'(if_valid), 64'h1);
            check("hold_pkt",   if_pkt, {32'hC, ins(32'h8)});
        end
        tick(); stall = 1'b0;
        smp();
        check("hold_rel_pkt", if_pkt, {32'hC, ins(32'h8)});
        tick();
        smp();
        check("post_hold_addr", 64'(imem_addr), 64'hC);
        check("post_hold_pkt",  if_pkt, {32'h10, ins(32'hC)});

        // Slow memory: redirect while waiting -> DRAIN
        tick(); ack_auto = 1'b0; ack_man = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
        smp();
        check("w1_addr",  64'(imem_addr),  64'h10);
        check("w1_busy",  64'(fetch_busy), 64'h1);
        check("w1_valid", 64'(if_valid),   64'h0);
        check("w1_instr", 64'(if_pkt[31:0]), 64'h0);
        tick(); redirect = 1'b0;
        smp();
        check("dr_addr",  64'(imem_addr),  64'h10);
        check("dr_req",   64'(imem_req),   64'h1);
        check("dr_busy",  64'(fetch_busy), 64'h1);
        tick(); ack_man = 1'b1;
        smp();
        check("dr_ack_valid", 64'(if_valid), 64'h0);
        check("dr_ack_addr",  64'(imem_addr), 64'h10);

        // Back-to-back redirects inside DRAIN: last one wins
        tick(); ack_man = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
        smp();
        check("rd1_addr", 64'(imem_addr),  64'h100);
        check("rd1_busy", 64'(fetch_busy), 64'h1);
        tick(); redirect_pc = 32'h300;
        smp();
        check("rd2_addr",  64'(imem_addr), 64'h100);
        check("rd2_valid", 64'(if_valid),  64'h0);
        tick(); redirect = 1'b0; ack_man = 1'b1;
        smp();
        check("rd3_addr", 64'(imem_addr), 64'h100);
        tick(); ack_man = 1'b0; ack_auto = 1'b1;
        smp();
        check("rd_last_addr", 64'(imem_addr), 64'h300);
        check("rd_last_pkt",  if_pkt, {32'h304, ins(32'h300)});

        // Redirect with ack and stall: data dropped, no HOLD, low bits masked
        tick(); redirect = 1'b1; redirect_pc = 32'h43; stall = 1'b1;
        smp();
        check("rs_valid", 64'(if_valid), 64'h0);
        check("rs_pkt",   if_pkt, {32'h308, 32'h0});
        tick(); redirect = 1'b0; stall = 1'b0;
        smp();
        check("rs_req",  64'(imem_req),  64'h1);
        check("rs_addr", 64'(imem_addr), 64'h40);
        check("rs_pkt2", if_pkt, {32'h44, ins(32'h40)});

        // Reset asserted while in HOLD
        tick(); stall = 1'b1;
        smp();
        check("h2_pkt", if_pkt, {32'h48, ins(32'h44)});
        tick();
        smp();
        check("h2_req", 64'(imem_req), 64'h0);
        tick(); rst = 1'b0;
        smp();
        check("mr_req",   64'(imem_req), 64'h0);
        check("mr_valid", 64'(if_valid), 64'h0);
        check("mr_pkt",   if_pkt, 64'h0);
        tick();
        smp();
        check("mr2_req",  64'(imem_req),   64'h0);
        check("mr2_busy", 64'(fetch_busy), 64'h0);
`ifdef IF_FETCH_PERF_CNT_EN
        check("mr_perf_f", 64'(perf_fetched),      64'h0);
        check("mr_perf_s", 64'(perf_stall_cycles), 64'h0);
`endif
        tick(); rst = 1'b1; stall = 1'b0;
        smp();
        check("rr_addr",  64'(imem_addr), 64'h0);
        check("rr_valid", 64'(if_valid),  64'h1);
        check("rr_pkt",   if_pkt, {32'h4, ins(32'h0)});

        // HOLD with redirect and stall together: redirect wins
        tick(); stall = 1'b1;
        smp();
        check("hr_addr", 64'(imem_addr), 64'h4);
`ifdef IF_FETCH_PERF_CNT_EN
        check("hr_perf_f", 64'(perf_fetched),      64'h1);
        check("hr_perf_s", 64'(perf_stall_cycles), 64'h0);
`endif
        tick(); redirect = 1'b1; redirect_pc = 32'h80;
        smp();
        check("hr_req",   64'(imem_req), 64'h0);
        check("hr_valid", 64'(if_valid), 64'h1);
`ifdef IF_FETCH_PERF_CNT_EN
        check("hr_perf_s1", 64'(perf_stall_cycles), 64'h1);
`endif
        tick(); redirect = 1'b0; stall = 1'b0;
        smp();
        check("hr_next_addr", 64'(imem_addr), 64'h80);
        check("hr_next_req",  64'(imem_req),  64'h1);
`ifdef IF_FETCH_PERF_CNT_EN
        check("hr_perf_f2", 64'(perf_fetched),      64'h1);
        check("hr_perf_s2", 64'(perf_stall_cycles), 64'h2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
